// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver with 5-8 data bits, optional odd/even
// parity, and 1 or 2 stop bits. Each completed frame gives a one-cycle rx_done
// strobe together with the data and the error flags.
// Optional feature: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3
// vote of rx_s, sampled at tick_cnt 5/6/7 for the start bit and 13/14/15 for the
// other bits.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                rx_s;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_flag_q, par_flag_d;
  logic                frm_flag_q, frm_flag_d;
  logic [1:0]          dbn_q, dbn_d;
  logic                sbn_q, sbn_d;
  logic                pen_q, pen_d;
  logic                ptype_q, ptype_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_done_q, rx_done_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;
  logic                bit_val_c;
  logic [BIT_W-1:0]    last_bit_c;
  logic                exp_par_c;

  // Input synchronizer: shift rx towards rx_s.
  if (SYNC_STAGES > 1) begin : g_sync_chain
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end else begin : g_sync_single
    assign sync_d = rx;
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  // Collect the two early samples; the third is the live rx_s at the decision tick.
  always_comb begin
    vote_d = vote_q;
    if (tick && (state_q != IDLE) &&
        ((tick_cnt_q[2:0] == 3'd5) || (tick_cnt_q[2:0] == 3'd6))) begin
      vote_d = {vote_q[0], rx_s};
    end
  end

  assign bit_val_c = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);

  // Vote sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vote_q <= 2'b11;
    else        vote_q <= vote_d;
  end
`else
  assign bit_val_c = rx_s;
`endif

  assign last_bit_c = BIT_W'(dbn_q) + BIT_W'(4);
  assign exp_par_c  = ptype_q ? (^shift_q) : ~(^shift_q);

  // Next-state, counter and output logic; everything advances on tick only.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    armed_d    = armed_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    frm_flag_d = frm_flag_q;
    dbn_d      = dbn_q;
    sbn_d      = sbn_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if ((state_q == IDLE) && rx_s) armed_d = 1'b1;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (armed_q && !rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
            armed_d    = 1'b0;
            shift_d    = '0;
            par_flag_d = 1'b0;
            frm_flag_d = 1'b0;
            dbn_d      = data_bit_num;
            sbn_d      = stop_bit_num;
            pen_d      = parity_en;
            ptype_d    = parity_type;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(7)) begin
            if (!bit_val_c) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(15)) begin
            shift_d[bit_cnt_q] = bit_val_c;
            bit_cnt_d          = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == last_bit_c) begin
              state_d    = pen_q ? PARITY : STOP;
              stop_cnt_d = 1'b0;
            end
          end
        end
        PARITY: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(15)) begin
            if (bit_val_c != exp_par_c) par_flag_d = 1'b1;
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
        STOP: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(15)) begin
            if (!bit_val_c) frm_flag_d = 1'b1;
            if (stop_cnt_q == sbn_q) begin
              state_d   = IDLE;
              rx_data_d = shift_q;
              perr_d    = par_flag_q;
              ferr_d    = frm_flag_q | ~bit_val_c;
              rx_done_d = 1'b1;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      dbn_q      <= 2'b11;
      sbn_q      <= 1'b0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      frm_flag_q <= frm_flag_d;
      dbn_q      <= dbn_d;
      sbn_q      <= sbn_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial driver pushes the expected frame
// results to a queue, and a monitor pops and compares them on every rx_done.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bit_num = 2'b11;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_div = 0;
  bit   busy_seen = 1'b0;
  exp_t exp_q[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .rx           (rx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk, changed away from the active edge.
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    tick = (tick_div == 0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every rx_done must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (rx_busy) busy_seen = 1'b1;
    if (rst_n && rx_done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious rx_done", 32'(rx_done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rx_data", 32'(rx_data), 32'(e.data));
        check_eq("parity_error", 32'(parity_error), 32'(e.perr));
        check_eq("frame_error", 32'(frame_error), 32'(e.ferr));
      end
    end
  end

  task automatic hold(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  task automatic set_cfg(input int nb, input bit pen, input bit ptype, input int nstop);
    data_bit_num = 2'(nb - 5);
    parity_en    = pen;
    parity_type  = ptype;
    stop_bit_num = (nstop == 2);
  endtask

  // Drive one full frame; glitch_bit >= 0 inverts rx for one tick mid data bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit ptype,
                            input bit pbad, input int nstop, input bit stop_low,
                            input int glitch_bit);
    logic [7:0] m;
    logic [7:0] dm;
    logic       pbit;
    exp_t       e;
    m    = 8'hFF >> (8 - nb);
    dm   = d & m;
    pbit = ptype ? (^dm) : ~(^dm);
    pbit = pbit ^ pbad;
    e.data = dm;
    e.perr = pen & pbad;
    e.ferr = stop_low;
    exp_q.push_back(e);
    set_cfg(nb, pen, ptype, nstop);
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < nb; i++) begin
      rx = dm[i];
      if (i == glitch_bit) begin
        hold(32);
        rx = ~dm[i];
        hold(4);
        rx = dm[i];
        hold(28);
      end else begin
        hold(BIT_CLKS);
      end
    end
    if (pen) begin
      rx = pbit;
      hold(BIT_CLKS);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = ~stop_low;
      hold(BIT_CLKS);
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 4 * BIT_CLKS;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    hold(5);
    check_eq("reset rx_data", 32'(rx_data), 32'd0);
    check_eq("reset rx_done", 32'(rx_done), 32'd0);
    check_eq("reset perr", 32'(parity_error), 32'd0);
    check_eq("reset ferr", 32'(frame_error), 32'd0);
    check_eq("reset busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    hold(BIT_CLKS);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, -1);
    drain("8N1 timeout");
    check_eq("busy after 8N1", 32'(rx_busy), 32'd0);
    hold(BIT_CLKS);

    // 8O1 0x5A, good then bad parity
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1, 1'b0, -1);
    drain("8O1 good timeout");
    hold(BIT_CLKS);
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1, 1'b0, -1);
    drain("8O1 bad timeout");
    hold(BIT_CLKS);

    // 5E2 0x13 back to back
    send_frame(8'h13, 5, 1'b1, 1'b1, 1'b0, 2, 1'b0, -1);
    send_frame(8'h13, 5, 1'b1, 1'b1, 1'b0, 2, 1'b0, -1);
    drain("5E2 timeout");
    hold(BIT_CLKS);

    // 7E1 0x55 with bad parity: different width and parity sense
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1, 1'b0, -1);
    drain("7E1 timeout");
    hold(BIT_CLKS);

    // 8N1 frame error, then a 3-frame break gives exactly one zero frame
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
    hold(BIT_CLKS);
    drain("ferr timeout");
    begin
      exp_t e;
      e.data = 8'h00;
      e.perr = 1'b0;
      e.ferr = 1'b1;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    hold(30 * BIT_CLKS);
    check_eq("break frames left", 32'(exp_q.size()), 32'd0);
    rx = 1'b1;
    hold(2 * BIT_CLKS);
    check_eq("busy after break", 32'(rx_busy), 32'd0);

    // Short glitch is a false start
    busy_seen = 1'b0;
    rx = 1'b0;
    hold(16);
    rx = 1'b1;
    hold(3 * BIT_CLKS);
    check_eq("glitch busy pulse", 32'(busy_seen), 32'd1);
    check_eq("glitch busy low", 32'(rx_busy), 32'd0);
    send_frame(8'h3E, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, -1);
    drain("post-glitch timeout");
    hold(BIT_CLKS);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 3);
    drain("vote timeout");
    hold(BIT_CLKS);
`endif

    // Reset during DATA of 0xC3
    set_cfg(8, 1'b0, 1'b0, 1);
    rx = 1'b0;
    hold(BIT_CLKS);
    rx = 1'b1;
    hold(BIT_CLKS);
    rx = 1'b1;
    hold(BIT_CLKS);
    rx = 1'b0;
    hold(BIT_CLKS / 2);
    check_eq("busy before reset", 32'(rx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid reset rx_data", 32'(rx_data), 32'd0);
    check_eq("mid reset rx_done", 32'(rx_done), 32'd0);
    check_eq("mid reset perr", 32'(parity_error), 32'd0);
    check_eq("mid reset ferr", 32'(frame_error), 32'd0);
    check_eq("mid reset busy", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    hold(4);
    rst_n = 1'b1;
    hold(2 * BIT_CLKS);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, -1);
    drain("post-reset timeout");
    hold(2 * BIT_CLKS);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
